// File: rtl/tt_sweep_checker_if.sv
// Signal bundle between the sweep checker and its environment: start and the f/g
// responses in; the {a,b,c,d} stimulus and the sweep result out.
interface tt_sweep_checker_if;
  logic       start;
  logic       f_in;
  logic       g_in;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       fail_valid;
  logic [3:0] fail_idx;

  modport master (
    output start, f_in, g_in,
    input  a, b, c, d, busy, done, pass, err_count, fail_valid, fail_idx
  );

  modport slave (
    input  start, f_in, g_in,
    output a, b, c, d, busy, done, pass, err_count, fail_valid, fail_idx
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 {a,b,c,d} vectors into a 4-in/2-out combinational block and checks f/g
// against F_EXP/G_EXP. Define STOP_ON_FAIL_EN to halt on the first mismatching vector.
module tt_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [15:0] F_EXP       = 16'h0000,
  parameter logic [15:0] G_EXP       = 16'h0000,
  parameter int unsigned HOLD_W      = 8
) (
  input logic               clk,
  input logic               rst_n,
  tt_sweep_checker_if.slave sw
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [3:0]        r_vec, w_vec_next;
  logic [HOLD_W-1:0] r_hold, w_hold_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              r_pass, w_pass_next;
  logic [4:0]        r_err_count, w_err_count_next;
  logic              r_fail_valid, w_fail_valid_next;
  logic [3:0]        r_fail_idx, w_fail_idx_next;
  logic              w_sample;
  logic              w_mis;

  // The response is sampled in the last cycle each vector is held.
  assign w_sample = (r_state == S_DRIVE) && (r_hold == HOLD_LAST);
  assign w_mis    = (sw.f_in != F_EXP[r_vec]) || (sw.g_in != G_EXP[r_vec]);

  always_comb begin
    w_state_next      = r_state;
    w_vec_next        = r_vec;
    w_hold_next       = r_hold;
    w_busy_next       = r_busy;
    w_done_next       = r_done;
    w_pass_next       = r_pass;
    w_err_count_next  = r_err_count;
    w_fail_valid_next = r_fail_valid;
    w_fail_idx_next   = r_fail_idx;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (sw.start) begin
          w_state_next      = S_DRIVE;
          w_vec_next        = 4'd0;
          w_hold_next       = '0;
          w_err_count_next  = 5'd0;
          w_fail_valid_next = 1'b0;
          w_fail_idx_next   = 4'd0;
          w_done_next       = 1'b0;
          w_pass_next       = 1'b0;
          w_busy_next       = 1'b1;
        end
      end
      S_DRIVE: begin
        w_hold_next = r_hold + 1'b1;
        if (w_sample) begin
          if (w_mis) begin
            w_err_count_next = r_err_count + 5'd1;
            if (!r_fail_valid) begin
              w_fail_valid_next = 1'b1;
              w_fail_idx_next   = r_vec;
            end
          end
`ifdef STOP_ON_FAIL_EN
          if (w_mis || (r_vec == 4'd15)) begin
`else
          if (r_vec == 4'd15) begin
`endif
            // vec is left untouched so a..d keep showing the last (or failing) stimulus.
            w_state_next = S_DONE;
            w_hold_next  = '0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_pass_next  = (w_err_count_next == 5'd0);
          end else begin
            w_vec_next  = r_vec + 4'd1;
            w_hold_next = '0;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= 4'd0;
      r_hold       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= 5'd0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_vec        <= w_vec_next;
      r_hold       <= w_hold_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_pass       <= w_pass_next;
      r_err_count  <= w_err_count_next;
      r_fail_valid <= w_fail_valid_next;
      r_fail_idx   <= w_fail_idx_next;
    end
  end

  assign sw.a          = r_vec[3];
  assign sw.b          = r_vec[2];
  assign sw.c          = r_vec[1];
  assign sw.d          = r_vec[0];
  assign sw.busy       = r_busy;
  assign sw.done       = r_done;
  assign sw.pass       = r_pass;
  assign sw.err_count  = r_err_count;
  assign sw.fail_valid = r_fail_valid;
  assign sw.fail_idx   = r_fail_idx;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: sweeps push expected vector/result events into queues, a monitor
// pops them whenever a checker presents a new vector or raises done.
module tb_tt_sweep_checker;
  localparam logic [15:0] F0 = 16'hF0F0;
  localparam logic [15:0] G0 = 16'h0FF0;
  localparam logic [15:0] F1 = 16'h6996;
  localparam logic [15:0] G1 = 16'h8001;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err;
    logic       fv;
    logic [3:0] fi;
    logic [3:0] v;
  } obs_t;

  typedef struct {
    int         id;
    int         rel;
    logic [3:0] vec;
    logic [4:0] err;
    logic       fv;
    logic [3:0] fi;
  } vev_t;

  typedef struct {
    int         id;
    int         rel;
    logic       pass;
    logic [4:0] err;
    logic       fv;
    logic [3:0] fi;
    logic [3:0] vec;
  } rev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] f_flip0 = 16'h0000;
  logic [15:0] g_flip0 = 16'h0000;
  int          cyc = 0;
  int          start_cyc [2] = '{0, 0};
  int          n_checks = 0;
  int          n_err = 0;
  vev_t        vq [$];
  rev_t        rq [$];
  obs_t        prev_obs [2] = '{default: '0};

  tt_sweep_checker_if if0 ();
  tt_sweep_checker_if if1 ();

  tt_sweep_checker #(.HOLD_CYCLES(10), .F_EXP(F0), .G_EXP(G0), .HOLD_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .sw(if0)
  );
  tt_sweep_checker #(.HOLD_CYCLES(1), .F_EXP(F1), .G_EXP(G1), .HOLD_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .sw(if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [3:0] v0 = {if0.a, if0.b, if0.c, if0.d};
  wire [3:0] v1 = {if1.a, if1.b, if1.c, if1.d};

  // Behavioural block under test, with optional per-vector fault injection on dut0.
  assign if0.f_in = F0[v0] ^ f_flip0[v0];
  assign if0.g_in = G0[v0] ^ g_flip0[v0];
  assign if1.f_in = F1[v1];
  assign if1.g_in = G1[v1];

  obs_t obs0, obs1;
  assign obs0 = {if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_valid, if0.fail_idx, v0};
  assign obs1 = {if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_valid, if1.fail_idx, v1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Expected vector events up to (not including) relative cycle lim, then optionally the result.
  task automatic push_sweep(input int id, input int h, input logic [15:0] ff, input logic [15:0] gf,
                            input int lim, input logic push_res, input int r_rel, input logic r_pass,
                            input logic [4:0] r_err, input logic r_fv, input logic [3:0] r_fi,
                            input logic [3:0] r_vec);
    logic [4:0] err = 5'd0;
    logic       fv  = 1'b0;
    logic [3:0] fi  = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (1 + k * h < lim) vq.push_back('{id, 1 + k * h, 4'(k), err, fv, fi});
      if (ff[k] || gf[k]) begin
        if (!fv) begin
          fv = 1'b1;
          fi = 4'(k);
        end
        err = err + 5'd1;
      end
    end
    if (push_res) rq.push_back('{id, r_rel, r_pass, r_err, r_fv, r_fi, r_vec});
  endtask

  task automatic raw_start(input int id);
    @(negedge clk);
    if (id == 0) if0.start = 1'b1;
    else         if1.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic pulse_start(input int id);
    raw_start(id);
    start_cyc[id] = cyc;
    $display("dut%0d start at cycle %0d", id, cyc);
  endtask

  task automatic wait_done(input int id, input int maxc);
    logic seen = 1'b0;
    for (int n = 0; n < maxc && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = (id == 0) ? obs0.done : obs1.done;
    end
    chk($sformatf("dut%0d done within %0d cycles", id, maxc), 32'(seen), 32'd1);
  endtask

  // Monitor: a new vector while busy, or a rising done, consumes one expected event.
  initial begin
    obs_t cur;
    int   rel;
    vev_t ve;
    rev_t re;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        cur = (i == 0) ? obs0 : obs1;
        rel = cyc - start_cyc[i] + 1;
        if (rst_n && cur.busy && (!prev_obs[i].busy || cur.v != prev_obs[i].v)) begin
          if (vq.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL dut%0d unexpected vector: got vec %0d, required none", i, cur.v);
          end else begin
            ve = vq.pop_front();
            chk($sformatf("dut%0d vector owner", i), 32'(i), 32'(ve.id));
            chk($sformatf("dut%0d vec", i), 32'(cur.v), 32'(ve.vec));
            chk($sformatf("dut%0d vec %0d start cycle", i, ve.vec), 32'(rel), 32'(ve.rel));
            chk($sformatf("dut%0d vec %0d err_count", i, ve.vec), 32'(cur.err), 32'(ve.err));
            chk($sformatf("dut%0d vec %0d fail_valid", i, ve.vec), 32'(cur.fv), 32'(ve.fv));
            chk($sformatf("dut%0d vec %0d fail_idx", i, ve.vec), 32'(cur.fi), 32'(ve.fi));
            chk($sformatf("dut%0d vec %0d done/pass", i, ve.vec), 32'({cur.done, cur.pass}), 32'd0);
          end
        end
        if (rst_n && cur.done && !prev_obs[i].done) begin
          if (rq.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL dut%0d unexpected done: got done=1, required 0", i);
          end else begin
            re = rq.pop_front();
            $display("dut%0d sweep done: cycle=%0d pass=%0b err_count=%0d fail_valid=%0b fail_idx=%0d abcd=%b",
                     i, rel, cur.pass, cur.err, cur.fv, cur.fi, cur.v);
            chk($sformatf("dut%0d result owner", i), 32'(i), 32'(re.id));
            chk($sformatf("dut%0d done cycle", i), 32'(rel), 32'(re.rel));
            chk($sformatf("dut%0d pass", i), 32'(cur.pass), 32'(re.pass));
            chk($sformatf("dut%0d final err_count", i), 32'(cur.err), 32'(re.err));
            chk($sformatf("dut%0d final fail_valid", i), 32'(cur.fv), 32'(re.fv));
            chk($sformatf("dut%0d final fail_idx", i), 32'(cur.fi), 32'(re.fi));
            chk($sformatf("dut%0d final abcd", i), 32'(cur.v), 32'(re.vec));
            chk($sformatf("dut%0d busy at done", i), 32'(cur.busy), 32'd0);
          end
        end
        prev_obs[i] = cur;
      end
    end
  end

  initial begin
    if0.start = 1'b0;
    if1.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle dut0 outputs c%0d", n), 32'(obs0), 32'd0);
      chk($sformatf("idle dut1 outputs c%0d", n), 32'(obs1), 32'd0);
    end

    // Matching block, with a start pulse mid-sweep that must be ignored.
    push_sweep(0, 10, 16'h0000, 16'h0000, 161, 1'b1, 161, 1'b1, 5'd0, 1'b0, 4'd0, 4'd15);
    pulse_start(0);
    repeat (48) @(posedge clk);
    raw_start(0);
    wait_done(0, 200);

    // f wrong at vectors 3 and 12; restarted straight from DONE.
    f_flip0 = 16'h1008;
`ifdef STOP_ON_FAIL_EN
    push_sweep(0, 10, 16'h1008, 16'h0000, 41, 1'b1, 41, 1'b0, 5'd1, 1'b1, 4'd3, 4'd3);
`else
    push_sweep(0, 10, 16'h1008, 16'h0000, 161, 1'b1, 161, 1'b0, 5'd2, 1'b1, 4'd3, 4'd15);
`endif
    pulse_start(0);
    wait_done(0, 200);

    // One-cycle hold on the second checker.
    push_sweep(1, 1, 16'h0000, 16'h0000, 17, 1'b1, 17, 1'b1, 5'd0, 1'b0, 4'd0, 4'd15);
    pulse_start(1);
    wait_done(1, 40);

    // g wrong at vector 5.
    f_flip0 = 16'h0000;
    g_flip0 = 16'h0020;
`ifdef STOP_ON_FAIL_EN
    push_sweep(0, 10, 16'h0000, 16'h0020, 61, 1'b1, 61, 1'b0, 5'd1, 1'b1, 4'd5, 4'd5);
`else
    push_sweep(0, 10, 16'h0000, 16'h0020, 161, 1'b1, 161, 1'b0, 5'd1, 1'b1, 4'd5, 4'd15);
`endif
    pulse_start(0);
    wait_done(0, 200);

    // Asynchronous abort while vector 7 is on the outputs.
    g_flip0 = 16'h0000;
    push_sweep(0, 10, 16'h0000, 16'h0000, 74, 1'b0, 0, 1'b0, 5'd0, 1'b0, 4'd0, 4'd0);
    pulse_start(0);
    repeat (73) @(posedge clk);
    @(negedge clk);
    #2;
    chk("abort precondition dut0 vec", 32'(obs0.v), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("abort dut0 outputs before edge", 32'(obs0), 32'd0);
    chk("abort dut1 outputs before edge", 32'(obs1), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-abort idle dut0 c%0d", n), 32'(obs0), 32'd0);
    end
    chk("vector events left over", 32'(vq.size()), 32'd0);
    chk("result events left over", 32'(rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Stimulus-and-check stage wrapped around the 4-input, 2-output combinational block (inputs a,b,c,d; outputs f,g).
- Upstream role: drives all 16 input combinations in ascending order, a as MSB, holding each for a programmable number of cycles.
- Downstream role: samples f and g, compares them with expected truth tables, accumulates a mismatch count and reports pass/fail.
- Replaces the hand-written 16-step stimulus sequence with a self-checking hardware sweep.

Parameters:
- HOLD_CYCLES, 10, clock cycles each input vector is held; legal range >= 1.
- F_EXP, 16'h0000, expected f; bit i is the f value for vector i = {a,b,c,d}.
- G_EXP, 16'h0000, expected g; bit i is the g value for vector i.
- HOLD_W, 8, width of the hold counter; requires HOLD_CYCLES <= 2**HOLD_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse to begin a sweep; sampled in IDLE and DONE only.
- f_in  in  1  f output of the block under test.
- g_in  in  1  g output of the block under test.
- a  out  1  vector bit 3.
- b  out  1  vector bit 2.
- c  out  1  vector bit 1.
- d  out  1  vector bit 0.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid while done=1; 1 when err_count == 0.
- err_count  out  5  number of vectors where f or g mismatched; range 0..16.
- fail_valid  out  1  at least one mismatch has been recorded.
- fail_idx  out  4  index of the first mismatching vector.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs 0, including a..d, busy, done, pass, err_count, fail_valid and fail_idx; hold counter = 0.
- Vector register: vec[3:0] drives {a,b,c,d} directly from flops; no combinational path from any input to any output.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 -> DRIVE on the next edge.
  - On that transition: vec=0, hold=0, err_count=0, fail_valid=0, fail_idx=0, done=0, pass=0, busy=1.
- DRIVE:
  - Each cycle: hold <= hold+1.
  - When hold == HOLD_CYCLES-1, this is the sample cycle. The checker evaluates mis = (f_in != F_EXP[vec]) | (g_in != G_EXP[vec]).
  - On mis: err_count += 1. If fail_valid was 0, also set fail_valid=1 and fail_idx=vec.
  - On the sample cycle with vec != 15: vec <= vec+1, hold <= 0.
  - On the sample cycle with vec == 15: -> DONE, busy=0, done=1, pass=(final err_count == 0). The final count includes vector 15's result.
  - start is ignored in DRIVE; no restart mid-sweep.
- Timing:
  - Vector k is presented from cycle 1 + k*HOLD_CYCLES after the start edge, for HOLD_CYCLES cycles.
  - It is sampled in its last cycle.
  - Sweep length is 16*HOLD_CYCLES cycles; done rises on the edge after the last sample.
- HOLD_CYCLES=1: each vector is sampled in the same cycle it is presented. This is legal because the block under test is combinational.
- DONE:
  - vec holds 15.
  - Outputs hold until start=1, which behaves exactly as start from IDLE: everything clears on the same edge and the sweep begins.
- err_count width: 5 bits holds 16; no saturation is needed.
- Reset asserted mid-sweep: the sweep aborts immediately and all state returns to reset values. After release, the block waits in IDLE for start.

Optional Feature:
- STOP_ON_FAIL_EN defined:
  - On the first sample cycle with mis=1, the FSM goes DRIVE -> DONE on that edge.
  - err_count=1, fail_idx = the failing vec, pass=0.
  - vec stays frozen at the failing vector, so a..d keep the failing stimulus for debug.
- Not defined: the full 16-vector sweep always runs, as described above.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no start -> all outputs 0 and a..d remain 0000 for 20 cycles.
- Matching DUT: F_EXP=16'hF0F0, G_EXP=16'h0FF0, HOLD_CYCLES=10, model f/g from the tables; pulse start -> each vector lasts exactly 10 cycles, done at cycle 161, pass=1, err_count=0, fail_valid=0.
- Injected faults: same tables with f forced wrong at vectors 3 and 12 -> err_count=2, fail_valid=1, fail_idx=3, pass=0.
- Edge hold: HOLD_CYCLES=1, all-correct model -> vec increments every cycle 0..15, done 17 cycles after the start edge, pass=1.
- Restart and ignored start: pulse start at cycle 50 of a sweep -> no effect. Pulse start in DONE -> err_count/fail_valid/done clear the next cycle and vec=0.
- Async abort: assert rst_n at vector 7 between clock edges -> outputs clear immediately without waiting for a clock edge. With STOP_ON_FAIL_EN and a g fault at vector 5 -> done after 6*HOLD_CYCLES+1 cycles, a..d=0101, err_count=1.
